// File: rtl/rs232_pkg.sv
// rs232_pkg: definitions shared by the RS-232 receiver and transmitter.
// Holds the receiver FSM state encoding, the data-bit count and the parity
// polarity. parity_bit() gives the parity bit a transmitter would send for a byte.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rs232_state_t;

    localparam int DATA_BITS = 8;

    // 0 = even parity: the parity bit equals the XOR of the data bits.
    localparam logic PARITY_ODD = 1'b0;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        return (^data) ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// rs232_rx_if: signal bundle between the receiver and its user.
//   rx_i    serial line (idle high)
//   baud_i  bit period minus one, in clock cycles
//   psel_i  1 = a parity bit follows the data bits
//   d_o     received byte
//   dv_o    one-cycle strobe; d_o/perr_o/ferr_o are valid while it is high
//   perr_o  parity error of the strobed frame
//   ferr_o  framing error (stop bit sampled 0) of the strobed frame
//   busy_o  frame reception in progress
//   state_o FSM state, for debug
// Handshake: dv_o is a pure strobe with no ready; the consumer must take the
// byte in the cycle dv_o is high. The outputs hold until the next strobe.
// master: the user side (drives the line and config). slave: the receiver.
interface rs232_rx_if #(
    parameter int Width = 15
);
    import rs232_pkg::*;

    logic             rx_i;
    logic [Width-1:0] baud_i;
    logic             psel_i;
    logic [7:0]       d_o;
    logic             dv_o;
    logic             perr_o;
    logic             ferr_o;
    logic             busy_o;
    rs232_state_t     state_o;

    modport master (
        output rx_i, baud_i, psel_i,
        input  d_o, dv_o, perr_o, ferr_o, busy_o, state_o
    );

    modport slave (
        input  rx_i, baud_i, psel_i,
        output d_o, dv_o, perr_o, ferr_o, busy_o, state_o
    );

endinterface

// File: rtl/rs232_sync.sv
// rs232_sync: two-flop synchronizer for an asynchronous single-bit input.
// Resets to 1 so that an idle-high serial line causes no false edge after reset.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   i_d           asynchronous input
//   o_q           synchronized output
module rs232_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: UART receiver. Frame = start(0), 8 data bits LSB first,
// optional even parity bit, one stop bit(1).
//   clk_i, rst_i  clock, asynchronous active-high reset
//   bus           rs232_rx_if slave: rx_i, baud_i, psel_i in;
//                 d_o, dv_o, perr_o, ferr_o, busy_o, state_o out
// baud_i and psel_i are latched at the start edge, so they can change
// mid-frame without disturbing the frame in progress.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int Width = 15
) (
    input logic        clk_i,
    input logic        rst_i,
    rs232_rx_if.slave  bus
);
    logic                 w_rs;
    logic                 r_rs_d;
    logic                 w_fall;
    rs232_state_t         r_state;
    rs232_state_t         w_state_nx;
    logic [Width-1:0]     r_cnt;
    logic [Width-1:0]     r_baud;
    logic                 r_psel;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_pbit;
    logic [7:0]           r_d;
    logic                 r_dv;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 w_half;
    logic                 w_full;
    logic                 w_tick;

    rs232_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_d   (bus.rx_i),
        .o_q   (w_rs)
    );

    // Previous synchronized sample for start-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rs_d <= 1'b1;
        else       r_rs_d <= w_rs;
    end

    assign w_fall = r_rs_d & ~w_rs;
    assign w_half = (r_cnt == (r_baud >> 1));
    assign w_full = (r_cnt == r_baud);

    always_comb begin
        w_state_nx = r_state;
        w_tick     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_nx = ST_START;
            end
            ST_START: begin
                // Mid-start-bit check; a high line here was only a glitch.
                if (w_half) begin
                    w_tick     = 1'b1;
                    w_state_nx = w_rs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_full) begin
                    w_tick = 1'b1;
                    if (r_idx == 3'd7) w_state_nx = r_psel ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_full) begin
                    w_tick     = 1'b1;
                    w_state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                // A low stop bit parks the FSM in BREAK until the line recovers.
                if (w_full) begin
                    w_tick     = 1'b1;
                    w_state_nx = w_rs ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rs) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Bit-period counter: runs only in the timed states, restarts on every
    // sample tick and on every state change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_tick || (w_state_nx != r_state) ||
                     r_state == ST_IDLE || r_state == ST_BREAK) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_baud  <= '0;
            r_psel  <= 1'b0;
            r_idx   <= 3'd0;
            r_shift <= '0;
            r_pbit  <= 1'b0;
            r_d     <= 8'h00;
            r_dv    <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            if (r_state == ST_IDLE && w_fall) begin
                r_baud <= bus.baud_i;
                r_psel <= bus.psel_i;
            end
            if (r_state == ST_START && w_tick) r_idx <= 3'd0;
            if (r_state == ST_DATA && w_tick) begin
                r_shift[r_idx] <= w_rs;
                r_idx          <= r_idx + 3'd1;
            end
            if (r_state == ST_PARITY && w_tick) r_pbit <= w_rs;
            if (r_state == ST_STOP && w_tick) begin
                r_d    <= r_shift;
                r_perr <= r_psel & (r_pbit ^ parity_bit(r_shift));
                r_ferr <= ~w_rs;
                r_dv   <= 1'b1;
            end
        end
    end

    assign bus.d_o     = r_d;
    assign bus.dv_o    = r_dv;
    assign bus.perr_o  = r_perr;
    assign bus.ferr_o  = r_ferr;
    assign bus.busy_o  = (r_state != ST_IDLE);
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed scoreboard bench for rs232_rx.
module tb_rs232_rx;
    import rs232_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic prev_dv;

    // {ferr, perr, data}
    logic [9:0] exp_q[$];

    rs232_rx_if #(.Width(15)) bus ();

    rs232_rx #(.Width(15)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b, input int period);
        bus.rx_i = b;
        repeat (period) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int period,
                              input logic has_par, input logic pbit,
                              input logic stop, input logic exp_perr,
                              input logic exp_ferr);
        exp_q.push_back({exp_ferr, exp_perr, data});
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(data[i], period);
        if (has_par) drive_bit(pbit, period);
        drive_bit(stop, period);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d frames still expected, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && bus.dv_o === 1'b1) begin
            checks++;
            if (prev_dv) begin
                failures++;
                $display("FAIL dv_double: dv_o high two cycles in a row, required one");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dv: d_o=%h ferr=%b perr=%b, required no strobe",
                         bus.d_o, bus.ferr_o, bus.perr_o);
            end else begin
                logic [9:0] exp;
                exp = exp_q.pop_front();
                if ({bus.ferr_o, bus.perr_o, bus.d_o} !== exp) begin
                    failures++;
                    $display("FAIL frame: got ferr=%b perr=%b d=%h, required ferr=%b perr=%b d=%h",
                             bus.ferr_o, bus.perr_o, bus.d_o, exp[9], exp[8], exp[7:0]);
                end
            end
        end
        prev_dv = bus.dv_o;
    end

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic busy_seen;
        logic [7:0] rnd;
        checks   = 0;
        failures = 0;
        prev_dv  = 1'b0;
        rst        = 1'b1;
        bus.rx_i   = 1'b1;
        bus.baud_i = 15'd15;
        bus.psel_i = 1'b0;
        repeat (4) @(negedge clk);

        // reset state
        check1("rst_d", bus.d_o, 8'h00);
        check1("rst_dv", {7'd0, bus.dv_o}, 8'h00);
        check1("rst_perr", {7'd0, bus.perr_o}, 8'h00);
        check1("rst_ferr", {7'd0, bus.ferr_o}, 8'h00);
        check1("rst_busy", {7'd0, bus.busy_o}, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // plain frame
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain(100);
        check1("busy_after_plain", {7'd0, bus.busy_o}, 8'h00);

        // parity ok / bad
        bus.psel_i = 1'b1;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3D, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(100);
        bus.psel_i = 1'b0;
        drive_bit(1'b1, 32);

        // framing error then break, then recovery
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 40 * 16);
        check1("break_state", {5'd0, bus.state_o}, {5'd0, ST_BREAK});
        drive_bit(1'b1, 32);
        send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain(100);

        // glitch: 4 low cycles must not produce a frame
        drive_bit(1'b1, 32);
        busy_seen = 1'b0;
        bus.rx_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | bus.busy_o;
        end
        bus.rx_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | bus.busy_o;
        end
        check1("glitch_seen", {7'd0, busy_seen}, 8'h01);
        check1("glitch_busy_clear", {7'd0, bus.busy_o}, 8'h00);
        drive_bit(1'b1, 32);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain(100);
        drive_bit(1'b1, 32);

        // reset during data bit 3 (frame A5: bits 1,0,1,0)
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 8);
        check1("pre_rst_state", {5'd0, bus.state_o}, {5'd0, ST_DATA});
        #2;
        rst = 1'b1;
        #1;
        check1("mid_rst_d", bus.d_o, 8'h00);
        check1("mid_rst_busy", {7'd0, bus.busy_o}, 8'h00);
        check1("mid_rst_dv", {7'd0, bus.dv_o}, 8'h00);
        @(negedge clk);
        bus.rx_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 200);

        // baud change mid-frame: current frame at 15, next at 7
        bus.baud_i = 15'd15;
        fork
            send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                bus.baud_i = 15'd7;
            end
        join
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain(100);
        drive_bit(1'b1, 16);

        // loopback-style random stream at the minimum bit period, parity on
        bus.baud_i = 15'd3;
        bus.psel_i = 1'b1;
        drive_bit(1'b1, 8);
        for (int n = 0; n < 256; n++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, 4, 1'b1, ^rnd, 1'b1, 1'b0, 1'b0);
        end
        wait_drain(100);
        drive_bit(1'b1, 20);
        check1("end_busy", {7'd0, bus.busy_o}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
